// File: rtl/wb_stream_writer_pkg.sv
// Shared constants for the memory-to-stream DMA: register map, CSR bits, CTI codes, FSM states.
package wb_stream_writer_pkg;

  localparam logic [4:0] REG_CSR        = 5'h00;
  localparam logic [4:0] REG_START_ADDR = 5'h04;
  localparam logic [4:0] REG_BUF_SIZE   = 5'h08;
  localparam logic [4:0] REG_BURST_SIZE = 5'h0C;

  localparam int unsigned CSR_BUSY = 0;
  localparam int unsigned CSR_IRQ  = 1;
  localparam int unsigned CSR_ERR  = 2;

  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst,
    StDone
  } state_e;

endpackage

// File: rtl/wb_stream_writer_fifo.sv
// First-word-fall-through FIFO, depth 2**AW, with occupancy and free-slot outputs and a flush.
module wb_stream_writer_fifo #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   free_o
);

  localparam int unsigned Depth = 2**AW;

  logic [DW-1:0] mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(Depth));
  assign empty_o = (count_q == '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_i & (~full | pop_i);
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign free_o  = (AW+1)'(Depth) - count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_stream_writer.sv
// Wishbone burst-reading DMA feeding a valid/ready stream through a local FIFO.
// Bus-error abort is enabled by defining WB_STREAM_WRITER_ERR_EN.
module wb_stream_writer
  import wb_stream_writer_pkg::*;
#(
  parameter int unsigned WB_AW         = 32,
  parameter int unsigned WB_DW         = 32,
  parameter int unsigned FIFO_AW       = 5,
  parameter int unsigned MAX_BURST_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic [4:0]         wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic               wbs_we_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic [2:0]         wbs_cti_i,
  input  logic [1:0]         wbs_bte_i,
  output logic [31:0]        wbs_dat_o,
  output logic               wbs_ack_o,
  output logic               wbs_err_o,
  output logic [WB_DW-1:0]   stream_m_data_o,
  output logic               stream_m_valid_o,
  input  logic               stream_m_ready_i,
  output logic               irq_o
);

  localparam int unsigned WSB     = WB_DW / 8;
  localparam int unsigned WsbLog2 = $clog2(WSB);

  state_e      state_q, state_d;
  logic        busy_q, busy_d, irq_q, irq_d, err_q, err_d, wbs_ack_q;
  logic [31:0] start_addr_q, start_addr_d, buf_size_q, buf_size_d, burst_size_q, burst_size_d;
  logic [31:0] fetched_q, fetched_d, beat_q, beat_d, blen_q, blen_d;
  logic [31:0] words_total, remaining, burst_lim, blen;
  logic        wbs_req, wbs_wr, csr_wr, start, irq_clr, irq_set, last_beat, cyc;
  logic        fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [FIFO_AW:0] fifo_count, fifo_free;
  logic        unused_inputs;

  assign unused_inputs = ^{wbs_sel_i, wbs_cti_i, wbs_bte_i};

  assign wbs_req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_q;
  assign wbs_wr  = wbs_req & wbs_we_i;
  assign csr_wr  = wbs_wr && (wbs_adr_i == REG_CSR);
  assign start   = csr_wr & wbs_dat_i[CSR_BUSY] & ~busy_q;
  assign irq_clr = csr_wr & wbs_dat_i[CSR_IRQ];

  assign words_total = buf_size_q >> WsbLog2;
  assign remaining   = words_total - fetched_q;
  assign burst_lim   = (burst_size_q > MAX_BURST_LEN) ? MAX_BURST_LEN : burst_size_q;
  assign blen        = (burst_lim < remaining) ? burst_lim : remaining;
  assign last_beat   = (beat_q == blen_q - 32'd1);
  assign fifo_pop    = stream_m_valid_o & stream_m_ready_i;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    err_d        = err_q;
    start_addr_d = start_addr_q;
    buf_size_d   = buf_size_q;
    burst_size_d = burst_size_q;
    fetched_d    = fetched_q;
    beat_d       = beat_q;
    blen_d       = blen_q;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    irq_set      = 1'b0;
    cyc          = 1'b0;
    wbm_cti_o    = 3'b000;

    if (wbs_wr && !busy_q) begin
      unique case (wbs_adr_i)
        REG_START_ADDR: start_addr_d = wbs_dat_i;
        REG_BUF_SIZE:   buf_size_d   = wbs_dat_i;
        REG_BURST_SIZE: burst_size_d = wbs_dat_i;
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d    = 1'b1;
          err_d     = 1'b0;
          fetched_d = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        // Only launch a burst the FIFO can absorb entirely.
        if (32'(fifo_free) >= blen) begin
          blen_d  = blen;
          beat_d  = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        cyc       = 1'b1;
        wbm_cti_o = last_beat ? CTI_EOB : CTI_INC;
`ifdef WB_STREAM_WRITER_ERR_EN
        if (wbm_err_i) begin
          fifo_flush = 1'b1;
          err_d      = 1'b1;
          irq_set    = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end else
`endif
        if (wbm_ack_i && !wbm_err_i) begin
          fifo_push = 1'b1;
          fetched_d = fetched_q + 32'd1;
          beat_d    = beat_q + 32'd1;
          if (last_beat) state_d = (fetched_q + 32'd1 == words_total) ? StDone : StWait;
        end
      end
      StDone: begin
        if (fifo_empty || (fifo_count == (FIFO_AW+1)'(1) && fifo_pop)) begin
          irq_set = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    irq_d = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
      err_q        <= 1'b0;
      wbs_ack_q    <= 1'b0;
      start_addr_q <= '0;
      buf_size_q   <= '0;
      burst_size_q <= '0;
      fetched_q    <= '0;
      beat_q       <= '0;
      blen_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      irq_q        <= irq_d;
      err_q        <= err_d;
      wbs_ack_q    <= wbs_req;
      start_addr_q <= start_addr_d;
      buf_size_q   <= buf_size_d;
      burst_size_q <= burst_size_d;
      fetched_q    <= fetched_d;
      beat_q       <= beat_d;
      blen_q       <= blen_d;
    end
  end

  always_comb begin
    wbs_dat_o = '0;
    unique case (wbs_adr_i)
      REG_CSR:        wbs_dat_o = {29'd0, err_q, irq_q, busy_q};
      REG_START_ADDR: wbs_dat_o = start_addr_q;
      REG_BUF_SIZE:   wbs_dat_o = buf_size_q;
      REG_BURST_SIZE: wbs_dat_o = burst_size_q;
      default: ;
    endcase
  end

  wb_stream_writer_fifo #(
    .DW (WB_DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (wbm_dat_i),
    .pop_i   (fifo_pop),
    .data_o  (stream_m_data_o),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .free_o  (fifo_free)
  );

  assign wbm_adr_o        = WB_AW'(start_addr_q) + (WB_AW'(fetched_q) << WsbLog2);
  assign wbm_dat_o        = '0;
  assign wbm_sel_o        = '1;
  assign wbm_we_o         = 1'b0;
  assign wbm_cyc_o        = cyc;
  assign wbm_stb_o        = cyc;
  assign wbm_bte_o        = 2'b00;
  assign wbs_ack_o        = wbs_ack_q;
  assign wbs_err_o        = 1'b0;
  assign stream_m_valid_o = ~fifo_empty;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed bench for wb_stream_writer: memory model on the master port, CSR driver, stream sink.
module tb_wb_stream_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [4:0]  wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0, wbs_dat_o;
  logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_ack_o, wbs_err_o;
  logic [31:0] stream_m_data_o;
  logic        stream_m_valid_o, irq_o;
  logic        stream_m_ready_i = 1'b0;

  logic [31:0] mem [1024];
  logic        err_arm = 1'b0;
  logic        err_now;
  int unsigned acc_cnt = 0;
  int unsigned err_at = 0;
  logic [31:0] sq[$];
  logic [31:0] aq[$];
  logic [2:0]  cq[$];
  int n_checks = 0;
  int n_fail = 0;

  wb_stream_writer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wbm_adr_o        (wbm_adr_o),
    .wbm_dat_o        (wbm_dat_o),
    .wbm_sel_o        (wbm_sel_o),
    .wbm_we_o         (wbm_we_o),
    .wbm_cyc_o        (wbm_cyc_o),
    .wbm_stb_o        (wbm_stb_o),
    .wbm_cti_o        (wbm_cti_o),
    .wbm_bte_o        (wbm_bte_o),
    .wbm_dat_i        (wbm_dat_i),
    .wbm_ack_i        (wbm_ack_i),
    .wbm_err_i        (wbm_err_i),
    .wbs_adr_i        (wbs_adr_i),
    .wbs_dat_i        (wbs_dat_i),
    .wbs_sel_i        (4'hF),
    .wbs_we_i         (wbs_we_i),
    .wbs_cyc_i        (wbs_cyc_i),
    .wbs_stb_i        (wbs_stb_i),
    .wbs_cti_i        (3'b000),
    .wbs_bte_i        (2'b00),
    .wbs_dat_o        (wbs_dat_o),
    .wbs_ack_o        (wbs_ack_o),
    .wbs_err_o        (wbs_err_o),
    .stream_m_data_o  (stream_m_data_o),
    .stream_m_valid_o (stream_m_valid_o),
    .stream_m_ready_i (stream_m_ready_i),
    .irq_o            (irq_o)
  );

  always #5 clk = ~clk;

  assign err_now   = err_arm && (acc_cnt == err_at);
  assign wbm_ack_i = wbm_stb_o & ~err_now;
  assign wbm_err_i = wbm_stb_o & err_now;
  assign wbm_dat_i = mem[wbm_adr_o[11:2]];

  always @(posedge clk) if (wbm_stb_o && wbm_ack_i) acc_cnt <= acc_cnt + 1;

  // Inputs only change just after posedge, so negedge values are what the next edge captures.
  always @(negedge clk) begin
    if (wbm_stb_o && wbm_ack_i) begin
      cq.push_back(wbm_cti_o);
      aq.push_back(wbm_adr_o);
    end
    if (stream_m_valid_o && stream_m_ready_i) sq.push_back(stream_m_data_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    logic got = 1'b0;
    @(posedge clk); #1;
    wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (wbs_ack_o) begin got = 1'b1; break; end
    end
    if (!got) check("wbs_write_ack", 32'(wbs_ack_o), 32'd1);
    @(posedge clk); #1;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic wb_read(input logic [4:0] a, output logic [31:0] d);
    logic got = 1'b0;
    d = 'x;
    @(posedge clk); #1;
    wbs_adr_i = a; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (wbs_ack_o) begin got = 1'b1; d = wbs_dat_o; break; end
    end
    if (!got) check("wbs_read_ack", 32'(wbs_ack_o), 32'd1);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic configure(input logic [31:0] sa, input logic [31:0] sz, input logic [31:0] bl);
    sq.delete(); aq.delete(); cq.delete();
    wb_write(5'h04, sa);
    wb_write(5'h08, sz);
    wb_write(5'h0C, bl);
    wb_write(5'h00, 32'd1);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    while (!irq_o && n < budget) begin @(negedge clk); n++; end
    check(tag, 32'(irq_o), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom();

    // Reset
    #2 rst_n = 1'b0;
    #10;
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_valid", 32'(stream_m_valid_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_cti", 32'(wbm_cti_o), 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_wbs_ack", 32'(wbs_ack_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wb_read(5'h00, rd);
    check("rst_csr", rd, 32'd0);
    wb_read(5'h08, rd);
    check("rst_buf_size", rd, 32'd0);

    // Test 1: 16 words from 0x40 in two 8-beat bursts, sink always ready
    stream_m_ready_i = 1'b1;
    configure(32'h40, 32'd64, 32'd8);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (wbm_stb_o) seen = 1'b1;
      @(negedge clk);
    end
    check("t1_start_latency", 32'(seen), 32'd1);
    wait_irq("t1_irq", 200);
    check("t1_beats", cq.size(), 32'd16);
    check("t1_words", sq.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t1_cti%0d", i), (i < cq.size()) ? 32'(cq[i]) : 'x,
            (i % 8 == 7) ? 32'd7 : 32'd2);
      check($sformatf("t1_adr%0d", i), (i < aq.size()) ? aq[i] : 'x, 32'h40 + 32'(4 * i));
      check($sformatf("t1_data%0d", i), (i < sq.size()) ? sq[i] : 'x, mem[16 + i]);
    end
    wb_read(5'h00, rd);
    check("t1_csr_done", rd, 32'd2);
    wb_write(5'h00, 32'd2);
    check("t1_irq_clear", 32'(irq_o), 32'd0);

    // Test 2: 5 words, burst 4 -> 4-beat burst then single EOB beat
    configure(32'h200, 32'd20, 32'd4);
    wait_irq("t2_irq", 200);
    check("t2_beats", cq.size(), 32'd5);
    check("t2_words", sq.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_cti%0d", i), (i < cq.size()) ? 32'(cq[i]) : 'x,
            (i >= 3) ? 32'd7 : 32'd2);
      check($sformatf("t2_data%0d", i), (i < sq.size()) ? sq[i] : 'x, mem[128 + i]);
    end
    wb_write(5'h00, 32'd2);

    // Tests 3 and 4: sink stalled, FIFO fills to 32, writes while busy are ignored
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + 32'(i);
    stream_m_ready_i = 1'b0;
    configure(32'h0, 32'd512, 32'd8);
    repeat (200) @(negedge clk);
    check("t3_stall_beats", cq.size(), 32'd32);
    check("t3_stall_stb", 32'(wbm_stb_o), 32'd0);
    check("t3_stall_valid", 32'(stream_m_valid_o), 32'd1);
    wb_write(5'h04, 32'h100);
    wb_read(5'h04, rd);
    check("t4_start_addr_kept", rd, 32'h0);
    wb_write(5'h00, 32'd1);
    wb_read(5'h00, rd);
    check("t4_csr_busy", rd, 32'd1);
    @(posedge clk); #1 stream_m_ready_i = 1'b1;
    wait_irq("t3_irq", 3000);
    check("t3_words", sq.size(), 32'd128);
    for (int i = 0; i < 128; i++)
      check($sformatf("t3_data%0d", i), (i < sq.size()) ? sq[i] : 'x, 32'hA500_0000 + 32'(i));

    // Test 5: irq clear, then reset pulse in the middle of a burst
    wb_write(5'h00, 32'd2);
    check("t5_irq_clear", 32'(irq_o), 32'd0);
    stream_m_ready_i = 1'b0;
    configure(32'h80, 32'd512, 32'd32);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (wbm_stb_o) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("t5_pre_cyc", 32'(wbm_cyc_o), 32'd1);
    check("t5_pre_valid", 32'(stream_m_valid_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("t5_rst_valid", 32'(stream_m_valid_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wb_read(5'h00, rd);
    check("t5_rst_csr", rd, 32'd0);
    wb_read(5'h04, rd);
    check("t5_rst_start_addr", rd, 32'd0);

`ifdef WB_STREAM_WRITER_ERR_EN
    // Test 6: bus error on the third beat aborts and flushes
    err_at  = acc_cnt + 2;
    err_arm = 1'b1;
    configure(32'h0, 32'd64, 32'd8);
    wait_irq("t6_irq", 100);
    err_arm = 1'b0;
    check("t6_cyc", 32'(wbm_cyc_o), 32'd0);
    check("t6_valid", 32'(stream_m_valid_o), 32'd0);
    check("t6_beats", cq.size(), 32'd2);
    wb_read(5'h00, rd);
    check("t6_csr", rd, 32'd6);
    wb_write(5'h00, 32'd2);
    wb_read(5'h00, rd);
    check("t6_csr_after_clear", rd, 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
